// File: rtl/pen_plotter_pkg.sv
// Shared constants and types for the grayscale frame writer.
//   IMG_PIXELS  default pixels per frame
//   GRAY_W_*    luma weights for R/G/B; they sum to 256, so the >>8 keeps white at 255
//   state_e     frame-writer FSM states
package pen_plotter_pkg;

  localparam int unsigned IMG_PIXELS = 40800;

  localparam logic [7:0] GRAY_W_R = 8'd77;
  localparam logic [7:0] GRAY_W_G = 8'd150;
  localparam logic [7:0] GRAY_W_B = 8'd29;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2,
    READY = 2'd3
  } state_e;

endpackage

// File: rtl/gray_frame_writer_if.sv
// Pixel-in / frame-buffer-out bundle of the grayscale frame writer.
//   slave  : writer side (takes pixels and frame control, drives memory port and status)
//   master : producer/consumer side (drives pixels and frame control, observes the rest)
interface gray_frame_writer_if #(
  parameter int unsigned ADDR_W = 16
);

  logic [23:0]       rgb_data;
  logic              pixel_done;
  logic [ADDR_W-1:0] pixel_cnt;
  logic              frame_done;
  logic              frame_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              frame_ready;
  logic [ADDR_W-1:0] wr_count;
  logic              err_overrun;
  logic              err_addr;
  logic              err_short;

  modport slave (
    input  rgb_data, pixel_done, pixel_cnt, frame_done, frame_ack,
    output mem_we, mem_addr, mem_wdata, frame_ready, wr_count,
           err_overrun, err_addr, err_short
  );

  modport master (
    output rgb_data, pixel_done, pixel_cnt, frame_done, frame_ack,
    input  mem_we, mem_addr, mem_wdata, frame_ready, wr_count,
           err_overrun, err_addr, err_short
  );

endinterface

// File: rtl/rgb2gray_pipe.sv
// Two-stage RGB-to-gray converter; the address rides along with its pixel.
//   in_valid/in_rgb/in_addr    : pixel entering the pipe
//   out_valid/out_gray/out_addr: converted pixel, exactly two cycles later
module rgb2gray_pipe
  import pen_plotter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [23:0]       in_rgb,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [7:0]        out_gray,
  output logic [ADDR_W-1:0] out_addr
);

  logic              s1_valid_q, s1_valid_d;
  logic [15:0]       prod_r_q, prod_r_d;
  logic [15:0]       prod_g_q, prod_g_d;
  logic [15:0]       prod_b_q, prod_b_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_valid_q, s2_valid_d;
  logic [7:0]        gray_q, gray_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [15:0]       sum_c;

  // Stage 1: weighted products; stage 2: sum and scale. Data regs load only on valid.
  always_comb begin
    s1_valid_d = in_valid;
    prod_r_d   = prod_r_q;
    prod_g_d   = prod_g_q;
    prod_b_d   = prod_b_q;
    s1_addr_d  = s1_addr_q;
    if (in_valid) begin
      prod_r_d  = 16'(in_rgb[23:16]) * 16'(GRAY_W_R);
      prod_g_d  = 16'(in_rgb[15:8])  * 16'(GRAY_W_G);
      prod_b_d  = 16'(in_rgb[7:0])   * 16'(GRAY_W_B);
      s1_addr_d = in_addr;
    end

    // Weights sum to 256, so the sum peaks at 65280 and never overflows 16 bits.
    sum_c      = prod_r_q + prod_g_q + prod_b_q;
    s2_valid_d = s1_valid_q;
    gray_d     = gray_q;
    s2_addr_d  = s2_addr_q;
    if (s1_valid_q) begin
      gray_d    = 8'(sum_c >> 8);
      s2_addr_d = s1_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      prod_r_q   <= '0;
      prod_g_q   <= '0;
      prod_b_q   <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      gray_q     <= '0;
      s2_addr_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      prod_r_q   <= prod_r_d;
      prod_g_q   <= prod_g_d;
      prod_b_q   <= prod_b_d;
      s1_addr_q  <= s1_addr_d;
      s2_valid_q <= s2_valid_d;
      gray_q     <= gray_d;
      s2_addr_q  <= s2_addr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_gray  = gray_q;
  assign out_addr  = s2_addr_q;

endmodule

// File: rtl/gray_frame_writer.sv
// Converts a stream of RGB pixels to gray and writes one frame into a buffer,
// then holds the buffer (frame_ready) until the consumer acknowledges it.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pixel/frame inputs, frame-buffer write port, status and sticky errors
module gray_frame_writer
  import pen_plotter_pkg::*;
#(
  parameter int unsigned IMG_PIXELS = pen_plotter_pkg::IMG_PIXELS,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  gray_frame_writer_if.slave bus
);

  state_e            state_q, state_d;
  logic              flush_cnt_q, flush_cnt_d;
  logic              frame_ready_q, frame_ready_d;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_addr_q, err_addr_d;
  logic              err_short_q, err_short_d;

  logic              addr_ok_c;
  logic              accept_c;
  logic              pipe_valid;
  logic [7:0]        pipe_gray;
  logic [ADDR_W-1:0] pipe_addr;

  assign addr_ok_c = 32'(bus.pixel_cnt) < IMG_PIXELS;
  // Pixels enter the pipe only while a frame is being (or about to be) received.
  assign accept_c  = bus.pixel_done && addr_ok_c && (state_q == IDLE || state_q == RECV);

  rgb2gray_pipe #(
    .ADDR_W(ADDR_W)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept_c),
    .in_rgb   (bus.rgb_data),
    .in_addr  (bus.pixel_cnt),
    .out_valid(pipe_valid),
    .out_gray (pipe_gray),
    .out_addr (pipe_addr)
  );

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    frame_ready_d = frame_ready_q;
    wr_count_d    = wr_count_q;
    err_overrun_d = err_overrun_q;
    err_addr_d    = err_addr_q;
    err_short_d   = err_short_q;

    if (pipe_valid && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + ADDR_W'(1);
    end

    if (bus.pixel_done) begin
      if (!addr_ok_c) begin
        err_addr_d = 1'b1;
      end
      if (state_q == FLUSH || state_q == READY) begin
        err_overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.frame_done) begin
          state_d     = FLUSH;
          flush_cnt_d = 1'b0;
          wr_count_d  = '0;
        end else if (accept_c) begin
          state_d    = RECV;
          wr_count_d = '0;
        end
      end
      RECV: begin
        if (bus.frame_done) begin
          state_d     = FLUSH;
          flush_cnt_d = 1'b0;
        end
      end
      FLUSH: begin
        // Two cycles drains the pipe; wr_count_d already includes the final write.
        if (flush_cnt_q) begin
          state_d       = READY;
          frame_ready_d = 1'b1;
          if (32'(wr_count_d) != IMG_PIXELS) begin
            err_short_d = 1'b1;
          end
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      READY: begin
        if (bus.frame_ack) begin
          state_d       = IDLE;
          frame_ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      flush_cnt_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      wr_count_q    <= '0;
      err_overrun_q <= 1'b0;
      err_addr_q    <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      frame_ready_q <= frame_ready_d;
      wr_count_q    <= wr_count_d;
      err_overrun_q <= err_overrun_d;
      err_addr_q    <= err_addr_d;
      err_short_q   <= err_short_d;
    end
  end

  assign bus.mem_we      = pipe_valid;
  assign bus.mem_addr    = pipe_addr;
  assign bus.mem_wdata   = pipe_gray;
  assign bus.frame_ready = frame_ready_q;
  assign bus.wr_count    = wr_count_q;
  assign bus.err_overrun = err_overrun_q;
  assign bus.err_addr    = err_addr_q;
  assign bus.err_short   = err_short_q;

endmodule

// File: tb/tb_gray_frame_writer.sv
// Bench for gray_frame_writer: directed frames plus random traffic, checked every
// cycle against a transaction-level model (write queue with due cycles, frame phase).
module tb_gray_frame_writer;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IMG    = 40800;

  localparam int M_IDLE  = 0;
  localparam int M_RECV  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_READY = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gray_frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

  gray_frame_writer #(
    .IMG_PIXELS(IMG),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int unsigned s;
    s = 32'd77 * 32'(p[23:16]) + 32'd150 * 32'(p[15:8]) + 32'd29 * 32'(p[7:0]);
    return 8'(s / 32'd256);
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned       due;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        gray;
  } wr_t;

  wr_t         wq[$];
  int unsigned m_cyc = 0;
  int          mode = M_IDLE;
  int          flush_left = 0;
  int unsigned m_cnt = 0;
  bit          m_ready, m_ovr, m_addr, m_short, m_we, m_acc;
  logic [ADDR_W-1:0] m_waddr;
  logic [7:0]        m_wdata;

  always @(posedge clk) begin
    m_cyc++;
    if (reset) begin
      mode    = M_IDLE;
      m_cnt   = 0;
      m_ready = 0;
      m_ovr   = 0;
      m_addr  = 0;
      m_short = 0;
      m_we    = 0;
      wq.delete();
    end else begin
      if (m_we && m_cnt != 32'd65535) m_cnt++;
      m_acc = 0;
      if (bus.pixel_done) begin
        if (32'(bus.pixel_cnt) >= IMG) m_addr = 1;
        if (mode == M_FLUSH || mode == M_READY) m_ovr = 1;
        else if (32'(bus.pixel_cnt) < IMG) m_acc = 1;
      end
      case (mode)
        M_IDLE: begin
          if (bus.frame_done) begin
            mode = M_FLUSH; flush_left = 2; m_cnt = 0;
          end else if (m_acc) begin
            mode = M_RECV; m_cnt = 0;
          end
        end
        M_RECV: if (bus.frame_done) begin mode = M_FLUSH; flush_left = 2; end
        M_FLUSH: begin
          flush_left--;
          if (flush_left == 0) begin
            mode = M_READY;
            m_ready = 1;
            if (m_cnt != IMG) m_short = 1;
          end
        end
        default: if (bus.frame_ack) begin mode = M_IDLE; m_ready = 0; end
      endcase
      if (m_acc) wq.push_back('{due: m_cyc + 1, addr: bus.pixel_cnt, gray: gray_of(bus.rgb_data)});
      m_we = 0;
      if (wq.size() > 0 && wq[0].due == m_cyc) begin
        m_we    = 1;
        m_waddr = wq[0].addr;
        m_wdata = wq[0].gray;
        void'(wq.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      if (m_we) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(m_waddr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      end
      chk("frame_ready", 32'(bus.frame_ready), 32'(m_ready));
      chk("wr_count", 32'(bus.wr_count), m_cnt);
      chk("err_overrun", 32'(bus.err_overrun), 32'(m_ovr));
      chk("err_addr", 32'(bus.err_addr), 32'(m_addr));
      chk("err_short", 32'(bus.err_short), 32'(m_short));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_in(input bit rst, input bit pd, input logic [ADDR_W-1:0] cnt,
                        input logic [23:0] rgb, input bit fd, input bit ack);
    reset          = rst;
    bus.pixel_done = pd;
    bus.pixel_cnt  = cnt;
    bus.rgb_data   = rgb;
    bus.frame_done = fd;
    bus.frame_ack  = ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, " frame_ready"}, 32'(bus.frame_ready), 32'd0);
    chk({tag, " wr_count"}, 32'(bus.wr_count), 32'd0);
    chk({tag, " err_overrun"}, 32'(bus.err_overrun), 32'd0);
    chk({tag, " err_addr"}, 32'(bus.err_addr), 32'd0);
    chk({tag, " err_short"}, 32'(bus.err_short), 32'd0);
  endtask

  initial begin
    cyc_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk_all_zero("reset");

    // Model pins: pure red and pure white.
    chk("model red", 32'(gray_of(24'hFF0000)), 32'h4C);
    chk("model white", 32'(gray_of(24'hFFFFFF)), 32'hFF);

    // Red at address 5, white at 6: write appears two cycles after the strobe.
    cyc_in(1'b0, 1'b1, 16'd5, 24'hFF0000, 1'b0, 1'b0);
    chk("red early we", 32'(bus.mem_we), 32'd0);
    idle(1);
    chk("red we", 32'(bus.mem_we), 32'd1);
    chk("red addr", 32'(bus.mem_addr), 32'd5);
    chk("red wdata", 32'(bus.mem_wdata), 32'h4C);
    cyc_in(1'b0, 1'b1, 16'd6, 24'hFFFFFF, 1'b0, 1'b0);
    idle(1);
    chk("white addr", 32'(bus.mem_addr), 32'd6);
    chk("white wdata", 32'(bus.mem_wdata), 32'hFF);

    // Reset one cycle after a strobe kills the in-flight pixel.
    cyc_in(1'b0, 1'b1, 16'd7, 24'h123456, 1'b0, 1'b0);
    cyc_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk_all_zero("midreset");
    idle(2);
    chk("midreset late we", 32'(bus.mem_we), 32'd0);

    // Full frame back-to-back, frame_done with the last pixel.
    for (int i = 0; i < int'(IMG); i++) begin
      cyc_in(1'b0, 1'b1, 16'(i), 24'($urandom), (i == int'(IMG) - 1), 1'b0);
    end
    idle(1);
    chk("full ready early", 32'(bus.frame_ready), 32'd0);
    idle(1);
    chk("full ready", 32'(bus.frame_ready), 32'd1);
    chk("full wr_count", 32'(bus.wr_count), IMG);
    chk("full err_short", 32'(bus.err_short), 32'd0);

    // Pixel while READY is dropped and flagged; ack returns to IDLE.
    cyc_in(1'b0, 1'b1, 16'd10, 24'hABCDEF, 1'b0, 1'b0);
    chk("ready overrun", 32'(bus.err_overrun), 32'd1);
    idle(1);
    chk("ready no we", 32'(bus.mem_we), 32'd0);
    chk("ready hold count", 32'(bus.wr_count), IMG);
    cyc_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    chk("ack clears ready", 32'(bus.frame_ready), 32'd0);
    cyc_in(1'b0, 1'b1, 16'd0, 24'h00FF00, 1'b0, 1'b0);
    chk("new frame count clear", 32'(bus.wr_count), 32'd0);
    idle(1);
    chk("green wdata", 32'(bus.mem_wdata), 32'h95);

    // Out-of-range address, then a short 100-pixel frame.
    cyc_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 16'(IMG), 24'h010203, 1'b0, 1'b0);
    chk("bad addr flag", 32'(bus.err_addr), 32'd1);
    idle(2);
    chk("bad addr no we", 32'(bus.mem_we), 32'd0);
    chk("bad addr count", 32'(bus.wr_count), 32'd0);
    for (int i = 0; i < 100; i++) begin
      cyc_in(1'b0, 1'b1, 16'(i), 24'($urandom), (i == 99), 1'b0);
    end
    idle(2);
    chk("short ready", 32'(bus.frame_ready), 32'd1);
    chk("short count", 32'(bus.wr_count), 32'd100);
    chk("short flag", 32'(bus.err_short), 32'd1);
    cyc_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);

    // Random traffic, including stray acks, bad addresses and occasional resets.
    cyc_in(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 6000; n++) begin
      bit rst, pd, fd, ack;
      logic [ADDR_W-1:0] cnt;
      rst = ($urandom_range(399, 0) == 0);
      pd  = ($urandom_range(2, 0) != 0);
      if ($urandom_range(29, 0) == 0) cnt = 16'(IMG + $urandom_range(24735, 0));
      else cnt = 16'($urandom_range(IMG - 1, 0));
      fd  = ($urandom_range(79, 0) == 0);
      ack = ($urandom_range(5, 0) == 0);
      cyc_in(rst, pd, cnt, 24'($urandom), fd, ack);
    end
    idle(4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
